cam_capture: RTL
================

Name: cam_capture

Overview:
- Camera capture front end. It sits directly upstream of the frame buffer and colour-processing top level.
- Samples an OV7670-style parallel camera interface (pclk/vsync/href/8-bit data, RGB444 output mode) in the system clock domain.
- Packs byte pairs into 12-bit pixels and 2:1 subsamples 320x240 down to 160x120.
- Produces the frame buffer write port (we/addr/data) and a one-clock end-of-frame pulse that drives capture_newframe.

Parameters:
- c_cam_cols, 320, camera pixels per line
- c_cam_rows, 240, camera lines per frame
- c_nb_cam_cols, 9, bits of camera column counter
- c_nb_cam_rows, 8, bits of camera row counter
- c_img_cols, 160, stored columns
- c_img_rows, 120, stored rows
- c_nb_img_pxls, 15, frame buffer address width
- c_nb_buf, 12, stored pixel width (4R,4G,4B)

Ports:
- clk  in  1  system clock; must be at least 4x cam_pclk
- rst  in  1  asynchronous, active-low reset
- cam_pclk  in  1  camera pixel clock, treated as data and sampled by clk
- cam_vsync  in  1  camera vsync; high means frame blanking
- cam_href  in  1  camera line valid
- cam_data  in  8  camera data byte
- capture_en  in  1  allows capture; evaluated only at frame start
- wea  out  1  frame buffer write enable
- addr  out  c_nb_img_pxls  frame buffer write address
- dout  out  c_nb_buf  frame buffer write data
- capture_newframe  out  1  one-clock pulse at end of a captured frame
- frame_err  out  1  status of the last captured frame: pixel count was not 19200
- busy  out  1  high while in state CAPTURE

Behaviour:
- Reset value of all outputs and registers is 0; the FSM resets to IDLE.
- Input synchronisation:
  - cam_pclk, cam_vsync, cam_href and cam_data each pass through 2 flip-flop stages.
  - A third register on pclk and vsync provides edge detection.
  - cam_href and cam_data are sampled only on a detected pclk rising edge.
- FSM states:
  - IDLE -> WAIT_VS: unconditional, on the first clock after reset.
  - WAIT_VS -> CAPTURE: on a vsync falling edge when capture_en=1. If capture_en=0 the FSM stays in WAIT_VS.
  - CAPTURE -> WAIT_VS: on a vsync rising edge.
  - On the CAPTURE -> WAIT_VS transition, capture_newframe=1 for exactly one clk, and frame_err is updated in the same cycle.
- Entering CAPTURE clears the column counter, row counter, byte toggle and write address.
- Byte packing (on each pclk rise with href=1):
  - toggle=0: latch red = data[3:0].
  - toggle=1: form pixel {red, data[7:4], data[3:0]}; data[7:4] is green and data[3:0] is blue.
  - Toggle flips on every such pclk rise.
- Column counter:
  - Increments after each completed pixel.
  - Saturates at c_cam_cols; pixels beyond 320 in a line are ignored.
- End of line (href falling edge):
  - Clears the column counter and the toggle; a dangling odd byte is discarded.
  - Increments the row counter, saturating at c_cam_rows.
- Subsampling: a pixel is stored only if column[0]=0, row[0]=0, and the row is < 240.
- Write port:
  - wea is high for exactly one clk, in the cycle after the second byte is detected.
  - addr and dout are valid in the same cycle as wea.
  - addr = (row/2)*160 + column/2, implemented as a counter that increments after each write.
  - Writes with addr > 19199 are suppressed, so the address never wraps.
- frame_err = 1 if the number of written pixels is not equal to 19200. It holds its value until the next end-of-frame.
- Reset mid-frame: all outputs go to 0 immediately and no further writes occur. After release, capture resumes only at the next vsync falling edge.
- A vsync rising edge in the middle of a line ends the frame normally, and frame_err reflects the short count.
- Simultaneous href fall and pclk rise: the href fall is processed and the byte is ignored.

Test Plan:
- Full frame of 320x240 with pclk = clk/4 and pixel value (col+row)&0xFFF -> exactly 19200 wea pulses with addr 0..19199 in order, one capture_newframe pulse, frame_err=0.
- First pixel bytes 0x0A then 0x5C -> first write has addr=0, dout=0xA5C. Camera pixel (col 1, row 0) is not written.
- Camera pixel at col 2, row 2 with bytes 0x03, 0x7E -> write at addr=161 with dout=0x37E. Pixels from camera row 1 produce no writes.
- Frame of only 100 lines -> 8000 writes, capture_newframe pulse, frame_err=1. Next full frame -> frame_err=0.
- capture_en=0 at the vsync falling edge, then raised mid-frame -> zero writes and no pulse for that frame. Capture starts at the following frame.
- rst asserted at line 50, then released -> wea=0, addr=0 and busy=0 while in reset. Nothing is written until the next vsync falling edge; the next frame is captured fully with frame_err=0.

Source files
------------

// File: rtl/cam_capture_if.sv
// Camera byte bus and frame buffer write port for cam_capture.
`timescale 1ns/1ps
interface cam_capture_if #(
    parameter int NB_PXLS = 15,
    parameter int NB_BUF  = 12
) ();
    logic               cam_pclk;
    logic               cam_vsync;
    logic               cam_href;
    logic [7:0]         cam_data;
    logic               wea;
    logic [NB_PXLS-1:0] addr;
    logic [NB_BUF-1:0]  dout;

    modport master (
        output cam_pclk, cam_vsync, cam_href, cam_data,
        input  wea, addr, dout
    );

    modport slave (
        input  cam_pclk, cam_vsync, cam_href, cam_data,
        output wea, addr, dout
    );
endinterface

// File: rtl/cam_capture.sv
// OV7670 RGB444 capture front end: byte pairing, 2:1 subsampling
// and frame buffer write generation in the system clock domain.
`timescale 1ns/1ps
module cam_capture #(
    parameter int c_cam_cols    = 320,
    parameter int c_cam_rows    = 240,
    parameter int c_nb_cam_cols = 9,
    parameter int c_nb_cam_rows = 8,
    parameter int c_img_cols    = 160,
    parameter int c_img_rows    = 120,
    parameter int c_nb_img_pxls = 15,
    parameter int c_nb_buf      = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         capture_en,
    cam_capture_if.slave bus,
    output logic         capture_newframe,
    output logic         frame_err,
    output logic         busy
);
    localparam logic [c_nb_cam_cols-1:0] lp_cols =
        c_nb_cam_cols'(c_cam_cols);
    localparam logic [c_nb_cam_rows-1:0] lp_rows =
        c_nb_cam_rows'(c_cam_rows);
    localparam logic [c_nb_img_pxls-1:0] lp_pxls =
        c_nb_img_pxls'(c_img_cols * c_img_rows);

    typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE} state_t;

    state_t state_q, state_d;

    logic [2:0] pclk_q;
    logic [2:0] vs_q;
    logic [1:0] href_q;
    logic [7:0] data1_q, data2_q;

    logic                     href_prev_q, href_prev_d;
    logic                     tog_q, tog_d;
    logic [3:0]               red_q, red_d;
    logic [c_nb_cam_cols-1:0] col_q, col_d;
    logic [c_nb_cam_rows-1:0] row_q, row_d;
    logic [c_nb_img_pxls-1:0] waddr_q, waddr_d;
    logic [c_nb_img_pxls-1:0] addr_q, addr_d;
    logic [c_nb_buf-1:0]      dout_q, dout_d;
    logic                     wea_q, wea_d;
    logic                     nf_q, nf_d;
    logic                     ferr_q, ferr_d;

    logic pclk_rise, vs_rise, vs_fall;

    assign pclk_rise = pclk_q[1] & ~pclk_q[2];
    assign vs_rise   = vs_q[1] & ~vs_q[2];
    assign vs_fall   = ~vs_q[1] & vs_q[2];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pclk_q      <= '0;
            vs_q        <= '0;
            href_q      <= '0;
            data1_q     <= '0;
            data2_q     <= '0;
            href_prev_q <= 1'b0;
            tog_q       <= 1'b0;
            red_q       <= '0;
            col_q       <= '0;
            row_q       <= '0;
            waddr_q     <= '0;
            addr_q      <= '0;
            dout_q      <= '0;
            wea_q       <= 1'b0;
            nf_q        <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pclk_q      <= {pclk_q[1:0], bus.cam_pclk};
            vs_q        <= {vs_q[1:0], bus.cam_vsync};
            href_q      <= {href_q[0], bus.cam_href};
            data1_q     <= bus.cam_data;
            data2_q     <= data1_q;
            href_prev_q <= href_prev_d;
            tog_q       <= tog_d;
            red_q       <= red_d;
            col_q       <= col_d;
            row_q       <= row_d;
            waddr_q     <= waddr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            wea_q       <= wea_d;
            nf_q        <= nf_d;
            ferr_q      <= ferr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        href_prev_d = href_prev_q;
        tog_d       = tog_q;
        red_d       = red_q;
        col_d       = col_q;
        row_d       = row_q;
        waddr_d     = waddr_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        wea_d       = 1'b0;
        nf_d        = 1'b0;
        ferr_d      = ferr_q;

        if (pclk_rise) begin
            href_prev_d = href_q[1];
        end

        unique case (state_q)
            IDLE: begin
                state_d = WAIT_VS;
            end
            WAIT_VS: begin
                if (vs_fall && capture_en) begin
                    state_d = CAPTURE;
                    col_d   = '0;
                    row_d   = '0;
                    tog_d   = 1'b0;
                    waddr_d = '0;
                end
            end
            CAPTURE: begin
                if (pclk_rise && href_q[1]) begin
                    tog_d = ~tog_q;
                    if (!tog_q) begin
                        red_d = data2_q[3:0];
                    end else if (col_q < lp_cols) begin
                        col_d = col_q + 1'b1;
                        // keep even columns of even rows only
                        if (!col_q[0] && !row_q[0] &&
                            row_q < lp_rows && waddr_q < lp_pxls) begin
                            wea_d   = 1'b1;
                            addr_d  = waddr_q;
                            dout_d  = {red_q, data2_q};
                            waddr_d = waddr_q + 1'b1;
                        end
                    end
                end else if (pclk_rise && href_prev_q) begin
                    col_d = '0;
                    tog_d = 1'b0;
                    if (row_q < lp_rows) begin
                        row_d = row_q + 1'b1;
                    end
                end
                if (vs_rise) begin
                    state_d = WAIT_VS;
                    nf_d    = 1'b1;
                    ferr_d  = (waddr_d != lp_pxls);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.wea          = wea_q;
    assign bus.addr         = addr_q;
    assign bus.dout         = dout_q;
    assign capture_newframe = nf_q;
    assign frame_err        = ferr_q;
    assign busy             = (state_q == CAPTURE);
endmodule
